// File: rtl/apb_slv_pkg.sv
// Shared definitions for the APB memory slave: FSM state encoding and default sizing.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACCESS = 2'd3
    } apb_state_e;

    localparam int DEF_MEM_DEPTH   = 64;
    localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/apb_slv_ram.sv
// Word storage for the APB memory slave: synchronous write, combinational read,
// whole array cleared by the asynchronous reset.
module apb_slv_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slv_mem.sv
// APB slave with WAIT_CYCLES wait states in front of a MEM_DEPTH-word memory.
//   state  | meaning
//   IDLE   | no transfer; penable without a setup phase is ignored
//   SETUP  | setup phase seen this cycle; address/data latched, counter loaded
//   WAIT   | access phase with wait states; counter runs down to 1
//   ACCESS | pready cycle; write commits on the edge that ends it
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module apb_slv_mem
    import apb_slv_pkg::*;
#(
    parameter int ADDR_WIDTH  = `ADDR_WIDTH,
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [DATA_WIDTH-1:0] prdata
);

    localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    apb_state_e            state;
    apb_state_e            phase;
    logic [3:0]            cnt;
    logic [IDX_W-1:0]      lat_idx;
    logic [IDX_W-1:0]      cur_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  lat_err;
    logic                  lat_wr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  cur_err;
    logic                  acc_err;
    logic                  acc_wr;
    logic                  finish;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rd_data;

    // A setup phase is only visible on the bus in the cycle itself, so SETUP is
    // decoded from the inputs while the registered state is IDLE or ACCESS.
    always_comb begin
        phase = state;
        if ((state == ST_IDLE || state == ST_ACCESS) && psel && !penable) begin
            phase = ST_SETUP;
        end
    end

    assign cur_idx = paddr[IDX_W+1:2];
    assign cur_err = (paddr[1:0] != 2'b00) ||
                     (paddr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_DEPTH));

    // With no wait states the transfer completes out of setup, before the latches hold it.
    assign rd_idx  = (phase == ST_SETUP) ? cur_idx : lat_idx;
    assign acc_err = (phase == ST_SETUP) ? cur_err : lat_err;
    assign acc_wr  = (phase == ST_SETUP) ? pwrite  : lat_wr;

    assign finish = ((phase == ST_SETUP) && (WAIT_CYCLES == 0)) ||
                    ((phase == ST_WAIT) && psel && penable && (cnt == 4'd1));

    assign mem_we = pready && lat_wr && !lat_err;

    apb_slv_ram #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_WIDTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (pclk),
        .rst_n (presetn),
        .we    (mem_we),
        .waddr (lat_idx),
        .wdata (lat_wdata),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_err   <= 1'b0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
        end else begin
            pready  <= finish;
            pslverr <= finish && acc_err;
            if (finish && !acc_wr) begin
                prdata <= acc_err ? '0 : rd_data;
            end

            case (phase)
                ST_SETUP: begin
                    cnt       <= WAIT_LOAD;
                    lat_idx   <= cur_idx;
                    lat_err   <= cur_err;
                    lat_wr    <= pwrite;
                    lat_wdata <= pwdata;
                    state     <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
                ST_WAIT: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (penable) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_slv_mem.md
APB_SLV_MEM -- requirements
Module: apb_slv_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH from apb_slv_define, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH from apb_slv_define, APB data width.
REQ-003 SHALL have parameter MEM_DEPTH, default 64, number of DATA_WIDTH-bit words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, legal range 0..15, wait states inserted per transfer.
REQ-005 SHALL have port pclk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port presetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port psel  input  1  slave select.
REQ-008 SHALL have port penable  input  1  access-phase strobe.
REQ-009 SHALL have port paddr  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have port pwrite  input  1  1=write, 0=read.
REQ-011 SHALL have port pwdata  input  DATA_WIDTH  write data.
REQ-012 SHALL have port pready  output  1  transfer complete, registered.
REQ-013 SHALL have port pslverr  output  1  transfer error, registered.
REQ-014 SHALL have port prdata  output  DATA_WIDTH  read data, registered.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, WAIT, ACCESS.
REQ-016 IDLE: psel=1 and penable=0 -> SETUP; penable=1 without prior setup SHALL be ignored (stay IDLE).
REQ-017 SETUP: load wait counter with WAIT_CYCLES, latch paddr/pwrite/pwdata; next state WAIT if WAIT_CYCLES>0, else ACCESS.
REQ-018 WAIT: counter decrements each cycle with psel=penable=1; counter reaching 1 -> ACCESS.
REQ-019 ACCESS: pready=1 for exactly one cycle; next state SETUP if psel=1 and penable=0 that cycle (back-to-back), else IDLE.
REQ-020 Latency: with setup at cycle T0, pready SHALL be high at cycle T0+1+WAIT_CYCLES; low in every other cycle.
REQ-021 Word index = latched paddr[ADDR_WIDTH-1:2].
REQ-022 Error: paddr[1:0]!=0 or word index >= MEM_DEPTH -> pslverr=1 in the pready cycle only.
REQ-023 Error write SHALL NOT modify memory; error read SHALL return prdata=0.
REQ-024 Good write SHALL commit latched pwdata on the clock edge ending the pready cycle.
REQ-025 Good read: prdata = mem[index] in the pready cycle; prdata holds that value until the next read completes.
REQ-026 psel deasserted in SETUP or WAIT (abort) -> IDLE next cycle, no pready, no memory update.
REQ-027 Address/data changes during WAIT SHALL be ignored (latched values used).
REQ-028 Read of a word in the same cycle it is written SHALL be impossible (one transfer at a time); read after write returns new data.

Reset
REQ-029 presetn=0 SHALL immediately force FSM to IDLE, pready=0, pslverr=0, prdata=0, counter=0.
REQ-030 presetn=0 SHALL clear all memory words to 0.
REQ-031 Reset asserted mid-transfer SHALL drop the transfer: no write commit, no pready after release.
REQ-032 First transfer SHALL be accepted on the first setup cycle after presetn deasserts.

Structure
REQ-033 Shared package apb_slv_pkg SHALL hold the FSM state enum and defaults for MEM_DEPTH and WAIT_CYCLES; widths remain in apb_slv_define.
REQ-034 Storage SHALL be one sub-module apb_slv_ram (MEM_DEPTH x DATA_WIDTH, sync write, async reset clear, combinational read).
REQ-035 FSM, wait counter, decode and output registers SHALL live in apb_slv_mem.

Verification
REQ-036 WAIT_CYCLES=2: write 0xA5A5_0001 to 0x04, then read 0x04 -> pready 3 cycles after each setup, prdata=0xA5A5_0001, pslverr=0.
REQ-037 WAIT_CYCLES=0: back-to-back writes to 0x00,0x04,0x08 without idle -> pready every second cycle, all three words readable.
REQ-038 Read 0x100 (index 64, MEM_DEPTH=64) and write 0x06 -> pslverr=1 with pready, prdata=0, memory unchanged.
REQ-039 psel dropped in WAIT during write 0xDEAD_BEEF to 0x10 -> no pready, later read 0x10 returns 0.
REQ-040 presetn pulsed low during WAIT of write to 0x0C -> outputs 0 immediately, read 0x0C after release returns 0.
REQ-041 penable=1 with psel=1 from IDLE (no setup) -> no pready, FSM stays IDLE.
